bram_snapshot: RTL
==================

Name: bram_snapshot

Overview:
- Fabric-side capture engine that writes a burst of samples into the FPGA-side port of the AXI-Lite-readable BRAM.
- The CPU arms it through a register pulse. It waits for an immediate or external trigger, then writes decimated samples at addresses 0..last_addr. It raises a sticky done flag so software can read the buffer over AXI-Lite.
- It sits directly upstream of the BRAM's fpga_clk port and drives bram_din, bram_addr and bram_we.

Parameters:
- DATA_WIDTH, 32, sample and BRAM word width.
- ADDR_WIDTH, 10, BRAM address width; depth is 2^ADDR_WIDTH.
- DEC_WIDTH, 16, width of the decimation control.

Ports:
- fpga_clk  in  1  single clock for all logic; same clock as the BRAM fpga-side port.
- rst  in  1  asynchronous, active-high reset.
- arm  in  1  single-cycle pulse from the register block; starts or restarts a capture.
- trig_sel  in  1  0 = trigger immediately once armed; 1 = trigger on rising edge of ext_trig.
- ext_trig  in  1  external trigger level, already synchronous to fpga_clk.
- decimation  in  DEC_WIDTH  write one sample, then skip the next N valid samples; 0 = keep every sample.
- last_addr  in  ADDR_WIDTH  final address written; capture length is last_addr+1.
- din  in  DATA_WIDTH  sample data.
- din_valid  in  1  sample qualifier.
- bram_din  out  DATA_WIDTH  write data to the BRAM.
- bram_addr  out  ADDR_WIDTH  write address to the BRAM.
- bram_we  out  1  write enable to the BRAM.
- busy  out  1  high in ARMED or CAPTURE.
- done  out  1  sticky; set at end of capture.
- wr_count  out  ADDR_WIDTH+1  number of samples written in the current capture.

Behaviour:
- Reset values:
  - State = IDLE.
  - bram_din, bram_addr, bram_we, busy, done, wr_count, wr_ptr, dec_cnt and ext_trig_d are all 0.
- State machine:
  - IDLE: arm -> ARMED.
  - ARMED: busy=1. Trigger -> CAPTURE, with wr_ptr=0, wr_count=0, dec_cnt=0.
    - trig_sel=0: the trigger fires on the first ARMED cycle.
    - trig_sel=1: the trigger fires when ext_trig=1 && ext_trig_d=0.
  - CAPTURE: busy=1. On each din_valid cycle:
    - dec_cnt==0: write, and reload dec_cnt <= decimation.
    - otherwise: no write, dec_cnt <= dec_cnt-1.
  - CAPTURE write action (registered):
    - bram_we <= 1, bram_addr <= wr_ptr, bram_din <= din.
    - wr_ptr <= wr_ptr+1, wr_count <= wr_count+1.
    - If wr_ptr==last_addr -> DONE.
  - DONE: done=1, busy=0, no writes. arm -> ARMED and clears done.
- Write timing:
  - Latency is 1 cycle from sampling din to bram_* outputs.
  - bram_we is a single-cycle strobe per write.
  - bram_we=0 on every cycle without a write.
  - bram_din and bram_addr hold their last value when not writing.
- ext_trig_d is registered every cycle in all states.
  - A trigger edge already present in the cycle arm is asserted is ignored; only edges seen while ARMED count.
- arm in any state (including mid-CAPTURE) aborts and re-enters ARMED:
  - done <= 0, wr_ptr <= 0, wr_count <= 0.
  - No write occurs in the arm cycle.
- din_valid low stalls the capture; dec_cnt and wr_ptr hold.
- last_addr = 2^ADDR_WIDTH-1 fills the full BRAM. wr_ptr never wraps past last_addr because capture ends exactly there.
- wr_count reaches last_addr+1 at done; that is why it is ADDR_WIDTH+1 bits wide.
- decimation and last_addr are sampled live. Software must hold them stable while busy; a change mid-capture has no defined effect.
- rst asserted mid-capture clears everything to reset values immediately. A write in flight is dropped.

Decomposition:
- Shared package holds:
  - State encoding (IDLE=2'd0, ARMED=2'd1, CAPTURE=2'd2, DONE=2'd3).
  - Default widths DATA_WIDTH, ADDR_WIDTH, DEC_WIDTH.
- One natural sub-module: edge_detect (rising-edge detector for ext_trig, with its own registered delay).
- Decimation counter and address pointer stay inline.

Test Plan:
- Immediate capture:
  - Stimulus: trig_sel=0, decimation=0, last_addr=7, din_valid=1, din counting from 100.
  - Required: 8 bram_we strobes, addr 0..7, data 100..107. done=1, busy=0, wr_count=8.
- Decimation:
  - Stimulus: decimation=2, last_addr=3, din = 0,1,2,… continuous valid.
  - Required: writes of 0,3,6,9 at addr 0..3, each strobe 3 cycles apart.
- External trigger:
  - Stimulus: trig_sel=1; ext_trig held high at arm, low 5 cycles, then high.
  - Required: no writes until the rising edge; first write is the sample in the first CAPTURE cycle.
- Stall:
  - Stimulus: din_valid toggling 1,0,0,1 pattern with decimation=0.
  - Required: bram_we only on valid cycles, addresses contiguous, no gaps.
- Re-arm mid-capture:
  - Stimulus: arm pulse after 3 of 8 writes.
  - Required: done stays 0, capture restarts at addr 0, final wr_count=8.
- Reset mid-capture:
  - Stimulus: rst pulsed during CAPTURE.
  - Required: all outputs 0 in the same cycle; then IDLE with no writes until the next arm.

Source files
------------

// File: rtl/bram_snapshot_pkg.sv
// Shared constants for the BRAM snapshot capture engine: default widths and FSM encoding.
package bram_snapshot_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 10;
    localparam int unsigned DEF_DEC_WIDTH  = 16;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

endpackage

// File: rtl/bram_snapshot_if.sv
// Control, sample and BRAM write-port bundle around the snapshot engine.
interface bram_snapshot_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DEC_WIDTH  = 16
);
    logic                  arm;
    logic                  trig_sel;
    logic                  ext_trig;
    logic [DEC_WIDTH-1:0]  decimation;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic [DATA_WIDTH-1:0] din;
    logic                  din_valid;
    logic [DATA_WIDTH-1:0] bram_din;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic                  bram_we;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH:0]   wr_count;

    // Register block / sample source side
    modport master (
        output arm, trig_sel, ext_trig, decimation, last_addr, din, din_valid,
        input  bram_din, bram_addr, bram_we, busy, done, wr_count
    );

    // Capture engine side
    modport slave (
        input  arm, trig_sel, ext_trig, decimation, last_addr, din, din_valid,
        output bram_din, bram_addr, bram_we, busy, done, wr_count
    );
endinterface

// File: rtl/bram_snapshot_edge_detect.sv
// Rising-edge detector with its own registered delay of the input level.
module bram_snapshot_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic rise_c
);
    logic sig_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sig_q <= 1'b0;
        else     sig_q <= sig_i;
    end

    assign rise_c = sig_i & ~sig_q;
endmodule

// File: rtl/bram_snapshot.sv
// Armed/triggered burst capture of decimated samples into the fabric-side BRAM write port.
module bram_snapshot
    import bram_snapshot_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DEC_WIDTH  = DEF_DEC_WIDTH
) (
    input  logic          fpga_clk,
    input  logic          rst,
    bram_snapshot_if.slave bus
);
    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

    logic [1:0]            state_q,     state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q,    wr_ptr_d;
    logic [CNT_WIDTH-1:0]  wr_count_q,  wr_count_d;
    logic [DEC_WIDTH-1:0]  dec_cnt_q,   dec_cnt_d;
    logic [DATA_WIDTH-1:0] bram_din_q,  bram_din_d;
    logic [ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
    logic                  bram_we_q,   bram_we_d;
    logic                  busy_q,      busy_d;
    logic                  done_q,      done_d;
    logic                  trig_rise_c;

    bram_snapshot_edge_detect u_trig_edge (
        .clk    (fpga_clk),
        .rst    (rst),
        .sig_i  (bus.ext_trig),
        .rise_c (trig_rise_c)
    );

    always_ff @(posedge fpga_clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            wr_count_q  <= '0;
            dec_cnt_q   <= '0;
            bram_din_q  <= '0;
            bram_addr_q <= '0;
            bram_we_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_count_q  <= wr_count_d;
            dec_cnt_q   <= dec_cnt_d;
            bram_din_q  <= bram_din_d;
            bram_addr_q <= bram_addr_d;
            bram_we_q   <= bram_we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // arm wins over everything, so a trigger edge coincident with arm is never seen
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_count_d  = wr_count_q;
        dec_cnt_d   = dec_cnt_q;
        bram_din_d  = bram_din_q;
        bram_addr_d = bram_addr_q;
        bram_we_d   = 1'b0;
        done_d      = done_q;

        if (bus.arm) begin
            state_d    = ST_ARMED;
            wr_ptr_d   = '0;
            wr_count_d = '0;
            dec_cnt_d  = '0;
            done_d     = 1'b0;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (!bus.trig_sel || trig_rise_c) begin
                        state_d    = ST_CAPTURE;
                        wr_ptr_d   = '0;
                        wr_count_d = '0;
                        dec_cnt_d  = '0;
                    end
                end
                ST_CAPTURE: begin
                    if (bus.din_valid) begin
                        if (dec_cnt_q == '0) begin
                            bram_we_d   = 1'b1;
                            bram_addr_d = wr_ptr_q;
                            bram_din_d  = bus.din;
                            wr_ptr_d    = wr_ptr_q + ADDR_WIDTH'(1);
                            wr_count_d  = wr_count_q + CNT_WIDTH'(1);
                            dec_cnt_d   = bus.decimation;
                            if (wr_ptr_q == bus.last_addr) begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            dec_cnt_d = dec_cnt_q - DEC_WIDTH'(1);
                        end
                    end
                end
                default: ;
            endcase
        end

        busy_d = (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
    end

    assign bus.bram_din  = bram_din_q;
    assign bus.bram_addr = bram_addr_q;
    assign bus.bram_we   = bram_we_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.wr_count  = wr_count_q;
endmodule
